// File: rtl/fs_accel_pool_pkg.sv
// Shared encodings and sizing helpers for the streaming pooling block.
package fs_accel_pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } pool_state_e;

  // Accumulator width: a KxK sum of DW-bit signed pixels needs 2*log2(K) guard bits.
  function automatic int acc_width(input int dw, input int k);
    return dw + 2 * $clog2(k);
  endfunction

endpackage

// File: rtl/fs_accel_pool_stream_if.sv
// Pixel input stream and pooled-pixel output stream of the pooling block.
interface fs_accel_pool_stream_if #(
  parameter int DW = 8
);
  logic signed [DW-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;

  // Producer of pixels / consumer of pooled results (the environment).
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  // The pooling block itself.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/fs_accel_pool_bank.sv
// Partial-result row bank: one accumulator per output column of the
// current window row, combinational read and synchronous write.
module fs_accel_pool_bank #(
  parameter int DEPTH = 32,
  parameter int W     = 10,
  parameter int AW    = 5
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic signed [W-1:0] wdata,
  output logic signed [W-1:0] rdata
);

  logic signed [W-1:0] mem_q [DEPTH];

  // Write the combined partial result back to its column slot.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/fs_accel_pool_stream.sv
// Streaming KxK non-overlapping max/average pooling with a per-column
// partial-result bank and a single-entry valid/ready output register.
module fs_accel_pool_stream
  import fs_accel_pool_pkg::*;
#(
  parameter int DW       = 8,
  parameter int POOL_K   = 2,
  parameter int MAX_COLS = 32,
  parameter int DIM_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               cfg_mode,
  input  logic [DIM_W-1:0]   cfg_in_cols,
  input  logic [DIM_W-1:0]   cfg_in_rows,
  fs_accel_pool_stream_if.slave s,
  output logic               busy,
  output logic               done,
  output logic               err_cfg
);

  localparam int LK    = $clog2(POOL_K);
  localparam int S     = 2 * LK;
  localparam int ACC_W = acc_width(DW, POOL_K);
  localparam int AW    = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;

  // Average of a window sum: add half an LSB of the result, then arithmetic
  // shift, i.e. round half toward +inf. The result always fits DW bits.
  function automatic logic signed [DW-1:0] round_avg(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W:0] t;
    t = {sum[ACC_W-1], sum} + (ACC_W+1)'(1 << (S-1));
    return DW'(t >>> S);
  endfunction

  pool_state_e          state_q;
  pool_mode_e           mode_q;
  logic [DIM_W-1:0]     cols_q, rows_q;
  logic [DIM_W-1:0]     kc_last_q, kr_last_q;
  logic [DIM_W-1:0]     r_q, c_q;
  logic                 busy_q, done_q, err_q;
  logic                 out_valid_q, out_last_q;
  logic signed [DW-1:0] out_data_q;

  // Start-time configuration check.
  logic [DIM_W-1:0] oc_new, or_new;
  logic             cfg_ok;

  assign oc_new = cfg_in_cols >> LK;
  assign or_new = cfg_in_rows >> LK;
  assign cfg_ok = (oc_new != '0) && (or_new != '0) && (32'(oc_new) <= 32'(MAX_COLS));

  // Pixel position decode; K is a power of two so window indices are bit fields.
  logic [LK-1:0] wr, wc;
  logic [AW-1:0] oc_addr;
  logic          accept, keep, first_px, win_end, emit, last_win;

  assign wr       = r_q[LK-1:0];
  assign wc       = c_q[LK-1:0];
  assign oc_addr  = c_q[LK +: AW];
  assign s.in_ready = (state_q == RUN) && (!out_valid_q || s.out_ready);
  assign accept   = s.in_valid && s.in_ready;
  assign keep     = (c_q <= kc_last_q) && (r_q <= kr_last_q);
  assign first_px = (wr == '0) && (wc == '0);
  assign win_end  = (&wr) && (&wc);
  assign emit     = accept && keep && win_end;
  assign last_win = (r_q == kr_last_q) && (c_q == kc_last_q);

  // Combine the incoming pixel with the column's partial result.
  logic signed [ACC_W-1:0] x_ext, rd, combined;
  logic signed [DW-1:0]    out_d;

  assign x_ext = {{(ACC_W-DW){s.in_data[DW-1]}}, s.in_data};

  fs_accel_pool_bank #(
    .DEPTH (MAX_COLS),
    .W     (ACC_W),
    .AW    (AW)
  ) u_bank (
    .clk   (clk),
    .we    (accept && keep),
    .addr  (oc_addr),
    .wdata (combined),
    .rdata (rd)
  );

  // Window accumulation: first pixel seeds the entry, later ones fold in.
  always_comb begin
    combined = x_ext;
    if (!first_px) begin
      if (mode_q == POOL_AVG) begin
        combined = rd + x_ext;
      end else if (x_ext > rd) begin
        combined = x_ext;
      end else begin
        combined = rd;
      end
    end
  end

  // Final pooled value presented to the output register.
  always_comb begin
    out_d = combined[DW-1:0];
    if (mode_q == POOL_AVG) begin
      out_d = round_avg(combined);
    end
  end

  // Frame FSM: configuration latch, raster counters and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= POOL_MAX;
      cols_q    <= '0;
      rows_q    <= '0;
      kc_last_q <= '0;
      kr_last_q <= '0;
      r_q       <= '0;
      c_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              mode_q    <= pool_mode_e'(cfg_mode);
              cols_q    <= cfg_in_cols;
              rows_q    <= cfg_in_rows;
              kc_last_q <= (oc_new << LK) - DIM_W'(1);
              kr_last_q <= (or_new << LK) - DIM_W'(1);
              r_q       <= '0;
              c_q       <= '0;
              busy_q    <= 1'b1;
              state_q   <= RUN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            if (c_q == cols_q - DIM_W'(1)) begin
              c_q <= '0;
              if (r_q == rows_q - DIM_W'(1)) begin
                state_q <= FLUSH;
              end else begin
                r_q <= r_q + DIM_W'(1);
              end
            end else begin
              c_q <= c_q + DIM_W'(1);
            end
          end
        end
        FLUSH: begin
          if (!out_valid_q || s.out_ready) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Single-entry output register; a completing window may replace an entry
  // that is being accepted in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (emit) begin
      out_valid_q <= 1'b1;
      out_last_q  <= last_win;
      out_data_q  <= out_d;
    end else if (s.out_ready) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign s.out_data  = out_data_q;
  assign s.out_valid = out_valid_q;
  assign s.out_last  = out_last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_cfg     = err_q;

endmodule

// File: tb/tb_fs_accel_pool_stream.sv
// Scoreboard bench for the streaming pooling block (K = 2).
module tb_fs_accel_pool_stream;

  localparam int DW    = 8;
  localparam int K     = 2;
  localparam int MAXC  = 32;
  localparam int DIM_W = 8;

  logic             clk = 1'b0;
  logic             reset, start, cfg_mode;
  logic [DIM_W-1:0] cfg_in_cols, cfg_in_rows;
  logic             busy, done, err_cfg;

  fs_accel_pool_stream_if #(.DW(DW)) bus ();

  fs_accel_pool_stream #(
    .DW(DW), .POOL_K(K), .MAX_COLS(MAXC), .DIM_W(DIM_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_mode(cfg_mode),
    .cfg_in_cols(cfg_in_cols), .cfg_in_rows(cfg_in_rows),
    .s(bus), .busy(busy), .done(done), .err_cfg(err_cfg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int exp_d[$];
  bit exp_l[$];
  int pix[$];
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
  bit gaps = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Downstream ready driver.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rdy_mode == 0)      bus.out_ready = 1'b1;
      else if (rdy_mode == 1) bus.out_ready = 1'($urandom_range(0, 1));
      else                    bus.out_ready = 1'b0;
    end
  end

  // Monitor: compare every accepted output against the scoreboard.
  initial begin : monitor
    int ed;
    bit el;
    forever begin
      @(negedge clk);
      #2;
      if (done) begin
        done_cnt++;
        chk("busy_low_at_done", int'(busy), 0);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_d.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%0d required=none", int'(bus.out_data));
        end else begin
          ed = exp_d.pop_front();
          el = exp_l.pop_front();
          chk("out_data", int'(bus.out_data), ed);
          chk("out_last", int'(bus.out_last), int'(el));
        end
      end
    end
  end

  task automatic push_exp(input int d, input bit l);
    exp_d.push_back(d);
    exp_l.push_back(l);
  endtask

  // Reference pooling over pix[] (row-major, cols wide).
  task automatic model_push(input int rows, input int cols, input int mode);
    int orr, occ, mx, sm, v;
    orr = rows / K;
    occ = cols / K;
    for (int wr = 0; wr < orr; wr++) begin
      for (int wc = 0; wc < occ; wc++) begin
        mx = -1000;
        sm = 0;
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K; j++) begin
            v = pix[(wr*K + i)*cols + wc*K + j];
            sm += v;
            if (v > mx) mx = v;
          end
        end
        push_exp(mode != 0 ? ((sm + 2) >>> 2) : mx, (wr == orr-1) && (wc == occ-1));
      end
    end
  endtask

  task automatic do_start(input int mode, input int rows, input int cols);
    start       = 1'b1;
    cfg_mode    = 1'(mode);
    cfg_in_rows = DIM_W'(rows);
    cfg_in_cols = DIM_W'(cols);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_px(input int v);
    bit hs;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = v[DW-1:0];
    hs = 1'b0;
    for (int n = 0; n < 2000 && !hs; n++) begin
      #1 hs = bus.in_ready;
      @(negedge clk);
    end
    if (!hs) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input int mode, input int rows, input int cols);
    do_start(mode, rows, cols);
    for (int i = 0; i < rows*cols; i++) send_px(pix[i]);
  endtask

  task automatic finish_frame(input int d0, input string name);
    for (int n = 0; n < 500 && done_cnt == d0; n++) begin
      @(negedge clk);
      #3;
    end
    chk({name, "_done_pulses"}, done_cnt - d0, 1);
    chk({name, "_pending"}, exp_d.size(), 0);
    chk({name, "_idle_in_ready"}, int'(bus.in_ready), 0);
  endtask

  task automatic ramp_frame();
    pix.delete();
    for (int i = 0; i < 16; i++) pix.push_back(i);
    push_exp(5, 0); push_exp(7, 0); push_exp(13, 0); push_exp(15, 1);
  endtask

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; cfg_mode = 1'b0;
    cfg_in_cols = '0; cfg_in_rows = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err_cfg), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 4x4 max ramp
    ramp_frame();
    d0 = done_cnt;
    send_frame(0, 4, 4);
    finish_frame(d0, "max4x4");

    // 4x4 avg with rounding and extremes
    pix = '{-1, -2, 3, 4,  -3, -4, 5, 6,  127, 127, -128, -128,  127, 127, -128, -128};
    push_exp(-2, 0); push_exp(5, 0); push_exp(127, 0); push_exp(-128, 1);
    d0 = done_cnt;
    send_frame(1, 4, 4);
    finish_frame(d0, "avg4x4");

    // 5x5 max: last column and row are cropped
    pix.delete();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        pix.push_back((c == 4 || r == 4) ? 120 : r*4 + c);
    push_exp(5, 0); push_exp(7, 0); push_exp(13, 0); push_exp(15, 1);
    d0 = done_cnt;
    send_frame(0, 5, 5);
    finish_frame(d0, "crop5x5");

    // Back-pressure: stall after first output, then random ready and gaps
    pix.delete();
    for (int i = 0; i < 16; i++) pix.push_back(int'($urandom_range(0, 255)) - 128);
    model_push(4, 4, 0);
    rdy_mode = 2;
    gaps = 1;
    d0 = done_cnt;
    fork
      send_frame(0, 4, 4);
      begin
        for (int n = 0; n < 300 && !bus.out_valid; n++) begin
          @(negedge clk);
          #2;
        end
        for (int n = 0; n < 10; n++) begin
          chk("stall_in_ready", int'(bus.in_ready), 0);
          chk("stall_out_data", int'(bus.out_data), exp_d[0]);
          @(negedge clk);
          #2;
        end
        rdy_mode = 1;
      end
    join
    finish_frame(d0, "stall");

    // Random avg and max frames with random valid/ready
    pix.delete();
    for (int i = 0; i < 48; i++) pix.push_back(int'($urandom_range(0, 255)) - 128);
    model_push(8, 6, 1);
    d0 = done_cnt;
    send_frame(1, 8, 6);
    finish_frame(d0, "rand_avg");

    pix.delete();
    for (int i = 0; i < 63; i++) pix.push_back(int'($urandom_range(0, 255)) - 128);
    model_push(7, 9, 0);
    d0 = done_cnt;
    send_frame(0, 7, 9);
    finish_frame(d0, "rand_max");
    rdy_mode = 0;
    gaps = 0;
    @(negedge clk);

    // Configuration errors
    do_start(0, 4, 1);
    #2;
    chk("err_narrow_pulse", int'(err_cfg), 1);
    chk("err_narrow_busy", int'(busy), 0);
    chk("err_narrow_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    #2;
    chk("err_narrow_clear", int'(err_cfg), 0);
    @(negedge clk);
    do_start(0, 4, 2*(MAXC+1));
    #2;
    chk("err_wide_pulse", int'(err_cfg), 1);
    chk("err_wide_busy", int'(busy), 0);
    chk("err_wide_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);

    // Reset mid-frame after 7 pixels
    ramp_frame();
    d0 = done_cnt;
    do_start(0, 4, 4);
    for (int i = 0; i < 7; i++) send_px(pix[i]);
    reset = 1'b1;
    @(negedge clk);
    #2;
    chk("mid_rst_in_ready", int'(bus.in_ready), 0);
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_out_data", int'(bus.out_data), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_no_done", done_cnt - d0, 0);
    chk("mid_rst_first_out_seen", exp_d.size(), 3);
    exp_d.delete();
    exp_l.delete();

    ramp_frame();
    d0 = done_cnt;
    send_frame(0, 4, 4);
    finish_frame(d0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fs_accel_pool_stream.md
Name: fs_accel_pool_stream

Overview:
- Parametrised, streaming successor to the fixed 13-lane max-pool unit.
- Receives an 8-bit signed feature map, one pixel per handshake, in row-major order. Performs non-overlapping KxK pooling (stride = K) in max or average mode, selected at run time.
- The fixed demux/compare bank is replaced by a MAX_COLS-deep partial-result row bank. The block emits one pooled pixel per completed window on a valid/ready output stream.
- Sits between the conv/activation output stream and the result write-back DMA.

Parameters:
- DW, 8, signed pixel width (input and output).
- POOL_K, 2, window size and stride; legal values are 2 and 4 only.
- MAX_COLS, 32, maximum output columns per row (depth of the partial-result bank).
- DIM_W, 8, width of the frame-dimension config fields.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; latches cfg_* when in IDLE.
- cfg_mode  in  1  0 = max pooling, 1 = average pooling.
- cfg_in_cols  in  DIM_W  input frame width.
- cfg_in_rows  in  DIM_W  input frame height.
- in_data  in  DW  input pixel, signed.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel.
- out_data  out  DW  pooled pixel, signed.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts the pixel.
- out_last  out  1  marks the final pooled pixel of the frame.
- busy  out  1  high in RUN and FLUSH.
- done  out  1  one-cycle pulse when the frame completes.
- err_cfg  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset:
  - State goes to IDLE.
  - Outputs in_ready, out_valid, out_last, busy, done, err_cfg are 0; out_data is 0.
  - Counters clear. Bank contents are don't-care; every entry is overwritten by the first pixel of its window.
  - Reset mid-frame aborts the frame with no done pulse.
- Output dimensions: OC = floor(in_cols/K), OR = floor(in_rows/K).
- start in IDLE:
  - If OC == 0, OR == 0, or OC > MAX_COLS: pulse err_cfg the next cycle and stay in IDLE.
  - Otherwise latch the config and go to RUN.
  - start is ignored outside IDLE.
- States:
  - IDLE: in_ready = 0.
  - RUN: in_ready = !out_valid || out_ready.
    - Counters r and c advance on each accepted pixel; c wraps at in_cols - 1, then r increments.
    - When the last frame pixel is accepted (r = in_rows-1, c = in_cols-1), go to FLUSH.
  - FLUSH: in_ready = 0. When out_valid is 0, or the output is accepted this cycle, go to IDLE and pulse done in the same cycle the block returns to IDLE.
- Cropping: pixels with c >= OC*K or r >= OR*K are accepted and discarded (no bank write, no output).
- Window indexing for a kept pixel: oc = c/K, wr = r mod K, wc = c mod K.
- Bank entries are ACC_W = DW + 2*log2(K) bits, signed.
  - First pixel of a window (wr = 0 and wc = 0): bank[oc] = sign-extended x.
  - Other pixels: max mode writes max(bank[oc], x); avg mode writes bank[oc] + x.
- Window completion (wr = K-1 and wc = K-1):
  - The combined value goes directly into the output register (the bank write is optional), and out_valid is set the cycle after acceptance. Latency is 1 cycle.
  - Max mode: output = combined value (fits DW).
  - Avg mode: output = (sum + 2^(S-1)) >>> S, with S = 2*log2(K). This rounds half toward +inf and always fits DW, so no saturation is needed.
- out_last = 1 with the pooled pixel for (OR-1, OC-1).
- Output register: single entry.
  - Holds out_data/out_valid stable until out_ready.
  - A simultaneous accept and new window completion replaces the entry with no bubble.
- in_ready depends combinationally on out_ready. This path is permitted.

Decomposition:
- Package fs_accel_pool_pkg holds:
  - Mode encodings POOL_MAX = 0 and POOL_AVG = 1.
  - State encoding IDLE/RUN/FLUSH.
  - Function acc_width(DW, K).
- Sub-module fs_accel_pool_bank: MAX_COLS x ACC_W register array with combinational read and synchronous write (address oc, write enable).
- FSM, counters, combine logic and output register live in the top level.

Test Plan:
- 4x4 max, K=2, pixels 0..15 row-major, out_ready = 1 -> outputs 5, 7, 13, 15; out_last on 15; done pulses once; busy falls with done.
- 4x4 avg, K=2, rows [-1,-2,3,4], [-3,-4,5,6], ... -> first output (-10+2)>>>2 = -2; second (18+2)>>>2 = 5; all outputs are rounded averages.
- 5x5 max, K=2 -> exactly 4 outputs; column 4 and row 4 are accepted but never affect results.
- Back-pressure: out_ready held 0 for 10 cycles after the first output -> in_ready = 0 and out_data held stable; resume gives no loss or duplication, checked against a reference model with random valid/ready.
- Config errors: start with in_cols = 1, and with in_cols = 2*(MAX_COLS+1) -> err_cfg pulse, state stays IDLE, in_ready = 0.
- Reset asserted mid-frame after 7 pixels -> all outputs 0 the next cycle, no done; a fresh 4x4 frame then gives correct results.
